seg_mem_ctrl: RTL and testbench
===============================

SEG_MEM_CTRL -- requirements
Module: seg_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameters SHALL be as follows, one per line:
- WIDTH, default 8: word width in bits.
- IDEPTH, default 32: instruction-segment depth in words.
- DDEPTH, default 32: data-segment depth in words.
- AW, default 8: address width in bits; AW SHALL satisfy 2^AW >= max(IDEPTH, DDEPTH).
REQ-003 Ports SHALL be as follows, one per line:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ld_valid  in  1  boot-load word present.
- ld_data  in  WIDTH  boot-load word.
- ld_last  in  1  final boot-load word.
- ld_ready  out  1  boot-load word accepted this cycle.
- i_req  in  1  instruction fetch request.
- i_addr  in  AW  instruction address, word index.
- i_valid  out  1  fetch response valid.
- i_rdata  out  WIDTH  fetched instruction.
- i_fault  out  1  fetch address out of range.
- d_req  in  1  data access request.
- d_we  in  1  access is a write.
- d_addr  in  AW  data address, word index from the data-segment base.
- d_wdata  in  WIDTH  write data.
- d_valid  out  1  data response valid.
- d_rdata  out  WIDTH  read data, or written data on a write.
- d_fault  out  1  data address out of range.
- busy  out  1  high in any state other than RUN.

Function
REQ-004 The controller SHALL use a 3-state FSM: CLEAR, LOAD and RUN.
REQ-005 CLEAR: one data word SHALL be zeroed per cycle at clr_ptr, from 0 to DDEPTH-1; after writing DDEPTH-1 the FSM SHALL go to LOAD; CLEAR SHALL last exactly DDEPTH cycles.
REQ-006 LOAD:
- ld_ready SHALL be 1.
- Each cycle with ld_valid=1, ld_data SHALL be written to the instruction segment at ld_ptr, and ld_ptr SHALL increment.
- The FSM SHALL go to RUN after accepting a word with ld_last=1 or a word at ld_ptr=IDEPTH-1, whichever comes first.
REQ-007 ld_ready SHALL be 0 in CLEAR and RUN; ld_valid SHALL be ignored in those states.
REQ-008 While busy=1, i_req and d_req SHALL be ignored: no write, and i_valid=d_valid=0 in the following cycle.
REQ-009 RUN fetch: i_req=1 at edge N SHALL give i_valid=1 at edge N+1, with i_rdata equal to the word at i_addr; i_valid SHALL be 0 in cycles following i_req=0.
REQ-010 RUN data read (d_req=1, d_we=0) SHALL give d_valid=1 one cycle later, with d_rdata equal to the word at d_addr.
REQ-011 RUN data write (d_req=1, d_we=1) SHALL store d_wdata at d_addr at that edge and give d_valid=1 one cycle later, with d_rdata=d_wdata (write-first).
REQ-012 The fetch port and data port SHALL be fully independent; simultaneous requests SHALL both complete with 1-cycle latency.
REQ-013 Addresses are range-checked:
- i_addr >= IDEPTH SHALL give i_valid=1, i_fault=1, i_rdata=0.
- d_addr >= DDEPTH SHALL give d_valid=1, d_fault=1, d_rdata=0, with no memory write.
REQ-014 i_fault and d_fault SHALL be 0 whenever the matching valid is 0, and on in-range responses.
REQ-015 A read of a data address in the cycle after a write to it SHALL return the new value.
REQ-016 Requests SHALL be accepted every cycle in RUN, with no back-pressure.

Reset
REQ-017 rst=1 at any edge SHALL set the FSM to CLEAR and set clr_ptr=0, ld_ptr=0.
REQ-018 The same edge SHALL set i_valid=d_valid=0, i_fault=d_fault=0, i_rdata=d_rdata=0, ld_ready=0 and busy=1.
REQ-019 Reset SHALL abort any in-progress CLEAR or LOAD; CLEAR and LOAD SHALL restart from address 0.
REQ-020 A request presented in the same cycle as rst=1 SHALL be dropped.
REQ-021 Instruction-segment contents are not cleared by reset and SHALL be overwritten only by LOAD.

Structure
REQ-022 A package seg_mem_pkg SHALL hold the FSM state enum typedef (CLEAR, LOAD, RUN) and the default parameter constants.
REQ-023 A sub-module seg_mem_bank SHALL provide one parametrised storage array with one synchronous write port and one registered read port; it SHALL be instantiated twice, once per segment.
REQ-024 The fault checks and the response registers SHALL reside in seg_mem_ctrl.

Verification
REQ-025 Reset, then idle -> busy=1 for exactly 32 cycles of CLEAR; ld_ready=1 from the following cycle; every data address then reads 0.
REQ-026 Load 0x11, 0x22, 0x33 with ld_last on 0x33 -> busy=0 the cycle after; fetch addresses 0..2 back-to-back -> i_rdata = 0x11, 0x22, 0x33 on consecutive cycles.
REQ-027 RUN: write 0xA5 to d_addr=5, then read d_addr=5 the next cycle -> write response d_rdata=0xA5; read response 0xA5, d_fault=0.
REQ-028 RUN: i_addr=40 and d_addr=32 with d_we=1 in the same cycle -> both faults=1, both rdata=0; data address 0 still reads its prior value.
REQ-029 Load 32 words with ld_last never asserted -> the FSM enters RUN after the 32nd word; a 33rd ld_valid is ignored (ld_ready=0).
REQ-030 Assert rst in the 3rd LOAD cycle -> busy=1, CLEAR restarts at address 0, outputs are at reset values, and the pending request produces no response.

Source files
------------

// File: rtl/seg_mem_pkg.sv
// Shared types and default sizing for the segmented memory controller.
package seg_mem_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_IDEPTH = 32;
    localparam int unsigned DEF_DDEPTH = 32;
    localparam int unsigned DEF_AW     = 8;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Index width needed to address a segment of the given depth (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/seg_mem_bank.sv
// One storage segment: synchronous write port, registered read port.
// The read register loads zero on any cycle without a read, and forwards
// same-cycle write data (write-first).
module seg_mem_bank
    import seg_mem_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DDEPTH,
    parameter int unsigned IW    = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [IW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/seg_mem_ctrl.sv
// Segmented memory controller: clears the data segment, boot-loads the
// instruction segment, then serves independent fetch and data ports.
module seg_mem_ctrl
    import seg_mem_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned IDEPTH = DEF_IDEPTH,
    parameter int unsigned DDEPTH = DEF_DDEPTH,
    parameter int unsigned AW     = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    input  logic             i_req,
    input  logic [AW-1:0]    i_addr,
    output logic             i_valid,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_fault,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_valid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_fault,
    output logic             busy
);

    localparam int unsigned IIW = idx_width(IDEPTH);
    localparam int unsigned DIW = idx_width(DDEPTH);

    state_e         state_q, state_d;
    logic [DIW-1:0] clr_ptr_q, clr_ptr_d;
    logic [IIW-1:0] ld_ptr_q, ld_ptr_d;
    logic           i_valid_q, i_valid_d;
    logic           i_fault_q, i_fault_d;
    logic           d_valid_q, d_valid_d;
    logic           d_fault_q, d_fault_d;
    logic           ld_ready_q, ld_ready_d;
    logic           busy_q, busy_d;

    logic           run_ok;
    logic           i_acc, d_acc, ld_acc, clr_we;
    logic           i_oor, d_oor;
    logic [IIW-1:0] i_idx;
    logic [DIW-1:0] d_idx;

    logic             ib_re;
    logic             db_we, db_re;
    logic [DIW-1:0]   db_waddr;
    logic [WIDTH-1:0] db_wdata;
    logic [WIDTH-1:0] ib_rdata, db_rdata;

    // Request qualification; anything presented alongside rst is dropped.
    always_comb begin
        run_ok   = (state_q == RUN) && !rst;
        i_acc    = run_ok && i_req;
        d_acc    = run_ok && d_req;
        ld_acc   = (state_q == LOAD) && ld_valid && !rst;
        clr_we   = (state_q == CLEAR) && !rst;
        i_oor    = 32'(i_addr) >= IDEPTH;
        d_oor    = 32'(d_addr) >= DDEPTH;
        i_idx    = IIW'(i_addr);
        d_idx    = DIW'(d_addr);
        ib_re    = i_acc && !i_oor;
        db_re    = d_acc && !d_oor;
        db_we    = clr_we || (d_acc && d_we && !d_oor);
        db_waddr = clr_we ? clr_ptr_q : d_idx;
        db_wdata = clr_we ? '0 : d_wdata;
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ld_ptr_d  = ld_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + DIW'(1);
                if (clr_ptr_q == DIW'(DDEPTH - 1)) begin
                    clr_ptr_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    ld_ptr_d = ld_ptr_q + IIW'(1);
                    if (ld_last || (ld_ptr_q == IIW'(IDEPTH - 1))) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        i_valid_d  = i_acc;
        i_fault_d  = i_acc && i_oor;
        d_valid_d  = d_acc;
        d_fault_d  = d_acc && d_oor;
        ld_ready_d = (state_d == LOAD);
        busy_d     = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            ld_ptr_q   <= '0;
            i_valid_q  <= 1'b0;
            i_fault_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            d_fault_q  <= 1'b0;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            ld_ptr_q   <= ld_ptr_d;
            i_valid_q  <= i_valid_d;
            i_fault_q  <= i_fault_d;
            d_valid_q  <= d_valid_d;
            d_fault_q  <= d_fault_d;
            ld_ready_q <= ld_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Instruction segment: written only by boot-load, read by fetch.
    seg_mem_bank #(
        .WIDTH (WIDTH),
        .DEPTH (IDEPTH),
        .IW    (IIW)
    ) u_ibank (
        .clk   (clk),
        .we    (ld_acc),
        .waddr (ld_ptr_q),
        .wdata (ld_data),
        .re    (ib_re),
        .raddr (i_idx),
        .rdata (ib_rdata)
    );

    // Data segment: zeroed during CLEAR, read/written by the data port in RUN.
    seg_mem_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DDEPTH),
        .IW    (DIW)
    ) u_dbank (
        .clk   (clk),
        .we    (db_we),
        .waddr (db_waddr),
        .wdata (db_wdata),
        .re    (db_re),
        .raddr (d_idx),
        .rdata (db_rdata)
    );

    assign ld_ready = ld_ready_q;
    assign busy     = busy_q;
    assign i_valid  = i_valid_q;
    assign i_fault  = i_fault_q;
    assign i_rdata  = ib_rdata;
    assign d_valid  = d_valid_q;
    assign d_fault  = d_fault_q;
    assign d_rdata  = db_rdata;

endmodule

// File: tb/tb_seg_mem_ctrl.sv
// Scoreboard bench for seg_mem_ctrl: responses are predicted at drive time
// and matched, including their exact cycle, when the DUT returns them.
module tb_seg_mem_ctrl;

    typedef struct {
        int unsigned due;
        logic [7:0]  data;
        logic        fault;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_valid, ld_last, ld_ready;
    logic [7:0] ld_data;
    logic       i_req, i_valid, i_fault;
    logic [7:0] i_addr, i_rdata;
    logic       d_req, d_we, d_valid, d_fault;
    logic [7:0] d_addr, d_wdata, d_rdata;
    logic       busy;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    exp_t        iq[$];
    exp_t        dq[$];
    logic [7:0]  imem_m [32];
    logic [7:0]  dmem_m [32];

    seg_mem_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_valid  (i_valid),
        .i_rdata  (i_rdata),
        .i_fault  (i_fault),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .d_fault  (d_fault),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic ev;
        exp_t e;
        ev = (iq.size() > 0) && (iq[0].due == cyc);
        check_eq("i_valid", 32'(i_valid), 32'(ev));
        if (ev) begin
            e = iq.pop_front();
            if (i_valid) begin
                check_eq("i_rdata", 32'(i_rdata), 32'(e.data));
                check_eq("i_fault", 32'(i_fault), 32'(e.fault));
            end
        end else begin
            check_eq("i_fault_idle", 32'(i_fault), 32'(0));
        end
        ev = (dq.size() > 0) && (dq[0].due == cyc);
        check_eq("d_valid", 32'(d_valid), 32'(ev));
        if (ev) begin
            e = dq.pop_front();
            if (d_valid) begin
                check_eq("d_rdata", 32'(d_rdata), 32'(e.data));
                check_eq("d_fault", 32'(d_fault), 32'(e.fault));
            end
        end else begin
            check_eq("d_fault_idle", 32'(d_fault), 32'(0));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        i_req = 1'b0; i_addr = 8'h00;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    endtask

    task automatic drive_i(input int unsigned a);
        exp_t e;
        i_req  = 1'b1;
        i_addr = 8'(a);
        e.due  = cyc + 1;
        e.fault = (a >= 32);
        e.data  = (a >= 32) ? 8'h00 : imem_m[a];
        iq.push_back(e);
    endtask

    task automatic drive_d(input logic we, input int unsigned a, input logic [7:0] wd);
        exp_t e;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = 8'(a);
        d_wdata = wd;
        e.due   = cyc + 1;
        e.fault = (a >= 32);
        if (a >= 32) begin
            e.data = 8'h00;
        end else if (we) begin
            dmem_m[a] = wd;
            e.data = wd;
        end else begin
            e.data = dmem_m[a];
        end
        dq.push_back(e);
    endtask

    // Reset edge with live requests/load attempts that must all be dropped.
    task automatic reset_with_traffic();
        rst = 1'b1;
        ld_valid = 1'b1; ld_data = 8'hC3;
        i_req = 1'b1; i_addr = 8'd1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd9; d_wdata = 8'hFF;
        cycle();
        rst = 1'b0;
        idle_inputs();
        check_eq("rst_busy", 32'(busy), 32'(1));
        check_eq("rst_ld_ready", 32'(ld_ready), 32'(0));
        check_eq("rst_i_valid", 32'(i_valid), 32'(0));
        check_eq("rst_d_valid", 32'(d_valid), 32'(0));
        check_eq("rst_i_rdata", 32'(i_rdata), 32'(0));
        check_eq("rst_d_rdata", 32'(d_rdata), 32'(0));
        check_eq("rst_faults", 32'({i_fault, d_fault}), 32'(0));
        for (int k = 0; k < 32; k++) dmem_m[k] = 8'h00;
    endtask

    // CLEAR lasts 32 cycles from the reset edge; requests during it are ignored.
    task automatic wait_clear();
        for (int k = 1; k < 32; k++) begin
            i_req = 1'b1; i_addr = 8'(k);
            d_req = 1'b1; d_we = k[0]; d_addr = 8'(k); d_wdata = 8'hEE;
            cycle();
            check_eq("clear_ld_ready", 32'(ld_ready), 32'(0));
            check_eq("clear_busy", 32'(busy), 32'(1));
        end
        idle_inputs();
        cycle();
        check_eq("load_ld_ready", 32'(ld_ready), 32'(1));
        check_eq("load_busy", 32'(busy), 32'(1));
    endtask

    task automatic ld_word(input int unsigned ptr, input logic [7:0] w, input logic last);
        ld_valid = 1'b1; ld_data = w; ld_last = last;
        imem_m[ptr] = w;
        cycle();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic read_all_data();
        for (int k = 0; k < 32; k++) begin
            drive_d(1'b0, k, 8'h00);
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 32; k++) imem_m[k] = 8'h00;

        // Power-up: reset, clear, boot-load three words.
        reset_with_traffic();
        wait_clear();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd7; d_wdata = 8'hEE;
        i_req = 1'b1; i_addr = 8'd0;
        ld_word(0, 8'h11, 1'b0);
        idle_inputs();
        check_eq("load1_busy", 32'(busy), 32'(1));
        ld_word(1, 8'h22, 1'b0);
        check_eq("load2_busy", 32'(busy), 32'(1));
        ld_word(2, 8'h33, 1'b1);
        check_eq("run_busy", 32'(busy), 32'(0));
        check_eq("run_ld_ready", 32'(ld_ready), 32'(0));

        // Whole data segment reads zero; fetch 0..2 back-to-back alongside.
        for (int k = 0; k < 32; k++) begin
            idle_inputs();
            drive_d(1'b0, k, 8'h00);
            if (k < 3) drive_i(k);
            cycle();
        end
        idle_inputs();

        // Write then read-after-write, and a prior value at address 0.
        drive_d(1'b1, 0, 8'h3C); cycle(); idle_inputs();
        drive_d(1'b1, 5, 8'hA5); cycle(); idle_inputs();
        drive_d(1'b0, 5, 8'h00); cycle(); idle_inputs();

        // Simultaneous out-of-range fetch and write; address 0 untouched.
        drive_i(40);
        drive_d(1'b1, 32, 8'h5A);
        cycle(); idle_inputs();
        drive_d(1'b0, 0, 8'h00);
        drive_i(31);
        cycle(); idle_inputs();
        drive_i(32);
        drive_d(1'b1, 31, 8'h77);
        cycle(); idle_inputs();
        drive_d(1'b0, 31, 8'h00);
        cycle(); idle_inputs();
        cycle();

        // Mixed random traffic across in-range and out-of-range addresses.
        for (int k = 0; k < 60; k++) begin
            idle_inputs();
            if ($urandom_range(1, 0) == 1) drive_i($urandom_range(45, 0));
            if ($urandom_range(3, 0) != 0)
                drive_d(1'($urandom_range(1, 0)), $urandom_range(40, 0), 8'($urandom_range(255, 0)));
            cycle();
        end
        idle_inputs();
        cycle();

        // Reset from RUN, then reset again on the third LOAD cycle.
        reset_with_traffic();
        wait_clear();
        ld_word(0, 8'hC1, 1'b0);
        ld_word(1, 8'hC2, 1'b0);
        reset_with_traffic();
        wait_clear();

        // Full 32-word load without ld_last; a 33rd word is refused.
        for (int k = 0; k < 32; k++) begin
            ld_word(k, 8'(8'h80 + k), 1'b0);
            if (k == 30) check_eq("load31_busy", 32'(busy), 32'(1));
        end
        check_eq("full_run_busy", 32'(busy), 32'(0));
        check_eq("full_ld_ready", 32'(ld_ready), 32'(0));
        ld_valid = 1'b1; ld_data = 8'hFF; ld_last = 1'b1;
        cycle();
        idle_inputs();
        check_eq("extra_ld_ready", 32'(ld_ready), 32'(0));

        // Fetch every instruction word and re-verify the data segment cleared.
        for (int k = 0; k < 33; k++) begin
            idle_inputs();
            drive_i(k);
            cycle();
        end
        idle_inputs();
        read_all_data();
        cycle();
        cycle();
        check_eq("sb_empty", 32'(iq.size() + dq.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
